// File: rtl/csi2_frame_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csi2_frame_sequencer_pkg                                                  |
// | Data-type codes, sequencer state encoding and beat-count helper.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package csi2_frame_sequencer_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;
    localparam logic [5:0] DT_RAW8     = 6'h2A;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_RAW12    = 6'h2C;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WAIT_FS  = 3'd1;
    localparam logic [2:0] c_ST_IN_FRAME = 3'd2;
    localparam logic [2:0] c_ST_IN_LINE  = 3'd3;
    localparam logic [2:0] c_ST_SKIP     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = c_ST_IDLE,
        WAIT_FS  = c_ST_WAIT_FS,
        IN_FRAME = c_ST_IN_FRAME,
        IN_LINE  = c_ST_IN_LINE,
        SKIP     = c_ST_SKIP
    } state_t;

    // ceil(wc / lanes) for lanes in {1,2,4}; 17-bit sum keeps wc=0xFFFF exact
    function automatic logic [15:0] f_ceil_beats(input logic [15:0] wc, input int lanes);
        logic [16:0] sum;
        sum = {1'b0, wc} + 17'(lanes - 1);
        case (lanes)
            1:       return sum[15:0];
            2:       return sum[16:1];
            default: return {1'b0, sum[16:2]};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/csi2_frame_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csi2_frame_sequencer_if                                                   |
// | Decoded packet-header and payload-beat bus from the header capture.       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface csi2_frame_sequencer_if;
    logic        hdr_vld;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_err;
    logic        payload_vld;

    modport master (output hdr_vld, hdr_vc, hdr_dt, hdr_wc, hdr_err, payload_vld);
    modport slave  (input  hdr_vld, hdr_vc, hdr_dt, hdr_wc, hdr_err, payload_vld);
endinterface
`default_nettype wire

// File: rtl/csi2_frame_sequencer_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csi2_frame_sequencer_watchdog                                             |
// | Idle-cycle counter; pulses o_tc on the TIMEOUT-th consecutive idle cycle. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module csi2_frame_sequencer_watchdog #(
    parameter int TIMEOUT = 65535
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_clear,
    input  wire  i_enable,
    output logic o_tc
);

    localparam logic [15:0] c_TERMINAL = 16'(TIMEOUT - 1);

    logic [15:0] r_cnt;

    assign o_tc = i_enable && !i_clear && (r_cnt == c_TERMINAL);

    always_ff @(posedge clk) begin
        if (rst || i_clear || !i_enable || o_tc) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/csi2_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csi2_frame_sequencer                                                      |
// | CSI-2 frame/line sequencer: fv/lv capture gating, counters, error flags.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module csi2_frame_sequencer
    import csi2_frame_sequencer_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int TIMEOUT = 65535
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   enable,
    input  wire  [1:0]            cfg_vc,
    input  wire  [5:0]            cfg_dt,
    input  wire  [15:0]           cfg_wc,
    input  wire  [15:0]           cfg_lines,
    input  wire                   err_clr,
    csi2_frame_sequencer_if.slave bus,
    output logic                  fv,
    output logic                  lv,
    output logic [15:0]           line_cnt,
    output logic [15:0]           frame_cnt,
    output logic                  err_ecc,
    output logic                  err_wc,
    output logic                  err_trunc,
    output logic                  err_lines,
    output logic                  err_tmo
);

    state_t      r_state, w_state_nxt, w_park;
    logic [15:0] r_beats, w_beats_nxt, w_hdr_beats;
    logic [15:0] r_line_cnt, r_frame_cnt;
    logic        r_fv, r_lv;
    logic [4:0]  r_err, w_err_set;
    logic        w_hdr_ok, w_wc_match, w_in_frame_st, w_wdog_tc;
    logic        w_proc, w_frame_start, w_line_done;
    logic        w_set_wc, w_set_trunc, w_set_lines;

    assign w_hdr_ok      = bus.hdr_vld && !bus.hdr_err && (bus.hdr_vc == cfg_vc);
    assign w_wc_match    = (cfg_wc == 16'd0) || (bus.hdr_wc == cfg_wc);
    assign w_hdr_beats   = f_ceil_beats(bus.hdr_wc, LANES);
    assign w_in_frame_st = (r_state == IN_FRAME) || (r_state == IN_LINE) || (r_state == SKIP);

    csi2_frame_sequencer_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (bus.hdr_vld || bus.payload_vld),
        .i_enable (w_in_frame_st),
        .o_tc     (w_wdog_tc)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_beats_nxt   = r_beats;
        w_park        = enable ? WAIT_FS : IDLE;
        w_proc        = 1'b0;
        w_frame_start = 1'b0;
        w_line_done   = 1'b0;
        w_set_wc      = 1'b0;
        w_set_trunc   = 1'b0;
        w_set_lines   = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = WAIT_FS;
            end
            WAIT_FS: begin
                if (!enable) begin
                    w_state_nxt = IDLE;
                end else if (w_hdr_ok && (bus.hdr_dt == DT_FS)) begin
                    w_state_nxt   = IN_FRAME;
                    w_frame_start = 1'b1;
                end
            end
            IN_FRAME: begin
                w_proc = w_hdr_ok;
            end
            IN_LINE, SKIP: begin
                // A header before the last beat aborts the line, then is handled as in IN_FRAME
                if (w_hdr_ok) begin
                    w_set_trunc = 1'b1;
                    w_state_nxt = IN_FRAME;
                    w_beats_nxt = 16'd0;
                    w_proc      = 1'b1;
                end else if (bus.payload_vld) begin
                    w_beats_nxt = r_beats - 16'd1;
                    if (r_beats == 16'd1) begin
                        w_state_nxt = IN_FRAME;
                        w_line_done = (r_state == IN_LINE);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_proc) begin
            if (bus.hdr_dt == DT_FE) begin
                w_state_nxt = w_park;
                w_set_lines = (cfg_lines != 16'd0) && (r_line_cnt != cfg_lines);
            end else if (bus.hdr_dt >= DT_LONG_MIN) begin
                w_beats_nxt = w_hdr_beats;
                w_set_wc    = (bus.hdr_dt == cfg_dt) && !w_wc_match;
                if (w_hdr_beats == 16'd0) begin
                    w_state_nxt = IN_FRAME;
                end else if ((bus.hdr_dt == cfg_dt) && w_wc_match) begin
                    w_state_nxt = IN_LINE;
                end else begin
                    w_state_nxt = SKIP;
                end
            end
        end

        if (w_wdog_tc) begin
            w_state_nxt = w_park;
            w_beats_nxt = 16'd0;
        end
    end

    assign w_err_set = {bus.hdr_vld && bus.hdr_err, w_set_wc, w_set_trunc, w_set_lines, w_wdog_tc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beats     <= 16'd0;
            r_fv        <= 1'b0;
            r_lv        <= 1'b0;
            r_line_cnt  <= 16'd0;
            r_frame_cnt <= 16'd0;
            r_err       <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_beats <= w_beats_nxt;
            r_fv    <= (w_state_nxt == IN_FRAME) || (w_state_nxt == IN_LINE) || (w_state_nxt == SKIP);
            r_lv    <= (w_state_nxt == IN_LINE);
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_line_cnt  <= 16'd0;
            end else if (w_line_done && (r_line_cnt != 16'hFFFF)) begin
                r_line_cnt <= r_line_cnt + 16'd1;
            end
            // A new error in the clear cycle wins
            r_err <= w_err_set | (r_err & ~{5{err_clr}});
        end
    end

    assign fv        = r_fv;
    assign lv        = r_lv;
    assign line_cnt  = r_line_cnt;
    assign frame_cnt = r_frame_cnt;
    assign err_ecc   = r_err[4];
    assign err_wc    = r_err[3];
    assign err_trunc = r_err[2];
    assign err_lines = r_err[1];
    assign err_tmo   = r_err[0];

endmodule
`default_nettype wire

// File: tb/tb_csi2_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_csi2_frame_sequencer                                                   |
// | Directed + random frames against a frame-level reference model.           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_csi2_frame_sequencer;
    import csi2_frame_sequencer_pkg::*;

    localparam int LANES   = 4;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst, enable, err_clr;
    logic [1:0]  cfg_vc;
    logic [5:0]  cfg_dt;
    logic [15:0] cfg_wc, cfg_lines;
    logic        fv, lv, err_ecc, err_wc, err_trunc, err_lines, err_tmo;
    logic [15:0] line_cnt, frame_cnt;
    logic [4:0]  errs;

    always #5 clk = ~clk;

    csi2_frame_sequencer_if bus();

    csi2_frame_sequencer #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cfg_vc    (cfg_vc),
        .cfg_dt    (cfg_dt),
        .cfg_wc    (cfg_wc),
        .cfg_lines (cfg_lines),
        .err_clr   (err_clr),
        .bus       (bus),
        .fv        (fv),
        .lv        (lv),
        .line_cnt  (line_cnt),
        .frame_cnt (frame_cnt),
        .err_ecc   (err_ecc),
        .err_wc    (err_wc),
        .err_trunc (err_trunc),
        .err_lines (err_lines),
        .err_tmo   (err_tmo)
    );

    assign errs = {err_ecc, err_wc, err_trunc, err_lines, err_tmo};

    int n_cmp = 0;
    int n_mis = 0;
    int lv_cycles = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a frame is open or not; an open line has beats remaining and is captured or skipped
    bit       m_armed, m_in_frame, m_capture;
    int       m_rem, m_idle, m_lines, m_frames;
    bit [4:0] m_err;   // {ecc, wc, trunc, lines, tmo}

    task automatic leave_frame();
        m_in_frame = 0;
        m_rem      = 0;
        m_idle     = 0;
        m_armed    = enable;
    endtask

    task automatic model_step();
        bit [4:0] set;
        bit       ok;
        set = '0;
        if (rst) begin
            m_armed = 0; m_in_frame = 0; m_capture = 0;
            m_rem = 0; m_idle = 0; m_lines = 0; m_frames = 0; m_err = '0;
            return;
        end
        if (bus.hdr_vld && bus.hdr_err) set[4] = 1;
        ok = bus.hdr_vld && !bus.hdr_err && (bus.hdr_vc == cfg_vc);
        if (!m_in_frame) begin
            m_idle = 0;
            if (!m_armed) m_armed = enable;
            else if (!enable) m_armed = 0;
            else if (ok && bus.hdr_dt == DT_FS) begin
                m_in_frame = 1;
                m_rem      = 0;
                m_frames   = (m_frames + 1) % 65536;
                m_lines    = 0;
            end
        end else begin
            if (bus.hdr_vld || bus.payload_vld) m_idle = 0;
            else m_idle++;
            if (m_idle == TIMEOUT) begin
                set[0] = 1;
                leave_frame();
            end else if (ok) begin
                if (m_rem > 0) begin
                    set[2] = 1;
                    m_rem  = 0;
                end
                if (bus.hdr_dt == DT_FE) begin
                    if (cfg_lines != 0 && m_lines != int'(cfg_lines)) set[1] = 1;
                    leave_frame();
                end else if (bus.hdr_dt >= 6'h10) begin
                    bit wc_ok;
                    wc_ok = (cfg_wc == 0) || (bus.hdr_wc == cfg_wc);
                    if (bus.hdr_dt == cfg_dt && !wc_ok) set[3] = 1;
                    m_rem     = (int'(bus.hdr_wc) + LANES - 1) / LANES;
                    m_capture = (bus.hdr_dt == cfg_dt) && wc_ok;
                end
            end else if (bus.payload_vld && m_rem > 0) begin
                m_rem--;
                if (m_rem == 0 && m_capture && m_lines < 65535) m_lines++;
            end
        end
        m_err = set | (m_err & ~{5{err_clr}});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("fv", fv, m_in_frame);
        check_eq("lv", lv, m_in_frame && m_rem > 0 && m_capture);
        check_eq("line_cnt", line_cnt, m_lines);
        check_eq("frame_cnt", frame_cnt, m_frames);
        check_eq("err_flags", errs, m_err);
        if (lv) lv_cycles++;
    endtask

    task automatic cyc(input bit hv, input bit [1:0] vc, input bit [5:0] dt,
                       input bit [15:0] wc, input bit he, input bit pv);
        bus.hdr_vld = hv; bus.hdr_vc = vc; bus.hdr_dt = dt;
        bus.hdr_wc  = wc; bus.hdr_err = he; bus.payload_vld = pv;
        tick();
        bus.hdr_vld = 0; bus.hdr_err = 0; bus.payload_vld = 0; err_clr = 0;
    endtask

    task automatic hdr(input bit [1:0] vc, input bit [5:0] dt, input bit [15:0] wc, input bit he);
        cyc(1, vc, dt, wc, he, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic beats(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(1, 3)));
            cyc(0, 0, 0, 0, 0, 1);
        end
    endtask

    initial begin
        rst = 1; enable = 0; err_clr = 0;
        cfg_vc = 2'd0; cfg_dt = DT_RAW10; cfg_wc = 16'd1600; cfg_lines = 16'd3;
        bus.hdr_vld = 0; bus.hdr_vc = 0; bus.hdr_dt = 0; bus.hdr_wc = 0;
        bus.hdr_err = 0; bus.payload_vld = 0;
        idle(2);
        check_eq("reset_fv", fv, 0);
        check_eq("reset_errs", errs, 0);
        rst = 0; enable = 1;
        idle(3);

        // normal frame
        lv_cycles = 0;
        hdr(0, DT_FS, 0, 0);
        for (int l = 0; l < 3; l++) begin
            idle(2);
            hdr(0, DT_RAW10, 16'd1600, 0);
            beats(400, 0);
        end
        idle(2);
        hdr(0, DT_FE, 0, 0);
        idle(2);
        check_eq("norm_lv_cycles", lv_cycles, 1200);
        check_eq("norm_line_cnt", line_cnt, 3);
        check_eq("norm_frame_cnt", frame_cnt, 1);
        check_eq("norm_errs", errs, 0);

        // wrong-VC traffic
        hdr(1, DT_FS, 0, 0);
        idle(2);
        check_eq("vc1_fs_fv", fv, 0);
        hdr(0, DT_FS, 0, 0);
        hdr(0, DT_RAW10, 16'd1600, 0);
        beats(100, 0);
        hdr(1, DT_RAW10, 16'd1600, 0);
        beats(300, 0);
        check_eq("vc1_mid_trunc", err_trunc, 0);
        check_eq("vc1_mid_lines", line_cnt, 1);
        hdr(0, DT_FE, 0, 0);
        err_clr = 1; idle(1);

        // word-count mismatch
        hdr(0, DT_FS, 0, 0);
        hdr(0, DT_RAW10, 16'd1596, 0);
        beats(399, 0);
        check_eq("wcm_err_wc", err_wc, 1);
        check_eq("wcm_line_cnt", line_cnt, 0);
        hdr(0, DT_FE, 0, 0);
        check_eq("wcm_err_lines", err_lines, 1);
        err_clr = 1; idle(1);

        // truncated line
        hdr(0, DT_FS, 0, 0);
        hdr(0, DT_RAW10, 16'd1600, 0);
        beats(200, 0);
        hdr(0, DT_FE, 0, 0);
        check_eq("trunc_flag", err_trunc, 1);
        check_eq("trunc_fv", fv, 0);
        check_eq("trunc_lv", lv, 0);
        check_eq("trunc_line_cnt", line_cnt, 0);
        err_clr = 1; idle(1);

        // ECC error then watchdog timeout
        hdr(0, DT_FS, 0, 1);
        check_eq("ecc_flag", err_ecc, 1);
        check_eq("ecc_fv", fv, 0);
        hdr(0, DT_FS, 0, 0);
        idle(TIMEOUT + 5);
        check_eq("tmo_flag", err_tmo, 1);
        check_eq("tmo_fv", fv, 0);
        err_clr = 1;
        hdr(0, DT_FS, 0, 1);
        check_eq("clr_vs_set_ecc", err_ecc, 1);
        check_eq("clr_tmo", err_tmo, 0);

        // reset mid-line
        err_clr = 1; idle(1);
        hdr(0, DT_FS, 0, 0);
        hdr(0, DT_RAW10, 16'd1600, 0);
        beats(50, 0);
        rst = 1; idle(1); rst = 0;
        beats(100, 0);
        check_eq("rst_mid_fv", fv, 0);
        check_eq("rst_mid_frame_cnt", frame_cnt, 0);
        check_eq("rst_mid_line_cnt", line_cnt, 0);

        // randomized frames, small lines
        cfg_wc = 16'd16;
        for (int f = 0; f < 60; f++) begin
            int nl;
            if ($urandom_range(9) == 0) enable = ~enable;
            else if (!enable && $urandom_range(1) == 0) enable = 1;
            if ($urandom_range(4) == 0) beats(int'($urandom_range(1, 3)), 0);
            hdr(($urandom_range(9) == 0) ? 2'd1 : 2'd0, DT_FS, 0, $urandom_range(9) == 0);
            nl = int'($urandom_range(0, 4));
            for (int l = 0; l < nl; l++) begin
                bit [5:0]  dt;
                bit [15:0] wc;
                int        nb, send;
                case ($urandom_range(5))
                    0:       dt = DT_RAW8;
                    1:       dt = DT_LS;
                    default: dt = DT_RAW10;
                endcase
                case ($urandom_range(5))
                    0:       wc = 16'd12;
                    1:       wc = 16'd0;
                    2:       wc = 16'($urandom_range(1, 40));
                    default: wc = 16'd16;
                endcase
                nb   = (int'(wc) + LANES - 1) / LANES;
                send = ($urandom_range(6) == 0) ? int'($urandom_range(0, nb)) : nb;
                if ($urandom_range(7) == 0) hdr(2'd2, DT_RAW10, 16'd16, 0);
                hdr(0, dt, wc, $urandom_range(19) == 0);
                beats(send, 20);
                if ($urandom_range(19) == 0) idle(TIMEOUT + 2);
                else idle(int'($urandom_range(0, 3)));
            end
            if ($urandom_range(9) == 0) enable = 0;
            hdr(0, DT_FE, 0, 0);
            if ($urandom_range(3) == 0) err_clr = 1;
            idle(int'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
